// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the div_n sequential divider:
//   - state_e : control FSM state encoding (IDLE, CALC, DONE)
//   - clog2() : constant function used to size the iteration counter
// ---------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << bits) < 64'(value)) begin
                bits = bits + 1;
            end
        end
        return (bits == 0) ? 1 : bits;
    endfunction

endpackage

// File: rtl/counter_div_n.sv
// ---------------------------------------------------------------------------
// counter_div_n
// Parametrised synchronous down-counter that paces the divider iterations.
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset (count cleared to 0)
//   load_i     load load_val_i into the counter (wins over dec_i)
//   load_val_i value to load
//   dec_i      decrement by one (stops at zero)
//   z_o        high when this decrement takes the count to zero
// ---------------------------------------------------------------------------
module counter_div_n #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             z_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flag the final step so the owner can finish on the same edge.
    assign z_o = dec_i && (cnt_q == WIDTH'(1));

endmodule

// File: rtl/div_n.sv
// ---------------------------------------------------------------------------
// div_n
// Sequential restoring divider, one quotient bit per clock.
// Parameters:
//   WIDTH   operand/result width (4..64)
//   SIGNED  0 = unsigned, 1 = two's complement (quotient truncates to zero)
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   init_in    start request, accepted in IDLE or DONE
//   A, B       dividend / divisor, sampled on the accepting edge
//   quotient   result quotient, valid while done=1
//   remainder  result remainder, valid while done=1
//   busy       division in progress
//   done       result valid (level) until next accepted start or reset
//   dv0        divide-by-zero flag, valid while done=1
// ---------------------------------------------------------------------------
module div_n
    import div_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init_in,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dv0
);

    localparam int CNT_W = clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend bits out, quotient bits in
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder (always < divisor)
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dv0_q, dv0_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_last;

    // Operand magnitudes and signs (signs forced to 0 in unsigned mode).
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign sign_a = (SIGNED != 0) ? A[WIDTH-1] : 1'b0;
    assign sign_b = (SIGNED != 0) ? B[WIDTH-1] : 1'b0;
    assign abs_a  = sign_a ? -A : A;
    assign abs_b  = sign_b ? -B : B;

    // One restoring step: the shifted remainder needs WIDTH+1 bits because it
    // can reach 2*divisor-1; after the subtract it fits in WIDTH bits again.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dvd_step;

    assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};
    assign q_bit     = ~trial[WIDTH];
    assign rem_step  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign dvd_step  = {dvd_q[WIDTH-2:0], q_bit};

    counter_div_n #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(WIDTH)),
        .dec_i      (cnt_dec),
        .z_o        (cnt_last)
    );

    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        busy_d    = busy_q;
        done_d    = done_q;
        dv0_d     = dv0_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (init_in) begin
                    if (B == '0) begin
                        // Divide by zero completes immediately with raw A.
                        state_d   = ST_DONE;
                        quo_out_d = '1;
                        rem_out_d = A;
                        dv0_d     = 1'b1;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        // Previous results and dv0 stay visible until the
                        // new result is written.
                        state_d   = ST_CALC;
                        dvd_d     = abs_a;
                        dvs_d     = abs_b;
                        rem_d     = '0;
                        neg_quo_d = sign_a ^ sign_b;
                        neg_rem_d = sign_a;
                        cnt_load  = 1'b1;
                        busy_d    = 1'b1;
                        done_d    = 1'b0;
                    end
                end
            end
            ST_CALC: begin
                cnt_dec = 1'b1;
                dvd_d   = dvd_step;
                rem_d   = rem_step;
                if (cnt_last) begin
                    // Most-negative / -1 wraps naturally through negation.
                    state_d   = ST_DONE;
                    quo_out_d = neg_quo_q ? -dvd_step : dvd_step;
                    rem_out_d = neg_rem_q ? -rem_step : rem_step;
                    dv0_d     = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dv0_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dv0_q     <= dv0_d;
        end
    end

    assign quotient  = quo_out_q;
    assign remainder = rem_out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dv0       = dv0_q;

endmodule

// File: tb/tb_div_n.sv
// ---------------------------------------------------------------------------
// tb_div_n
// Self-checking bench for div_n. Three instances: 16-bit unsigned (sel 0),
// 16-bit signed (sel 1) and 32-bit unsigned (sel 2). Expected results come
// from plain integer arithmetic on the operands.
// ---------------------------------------------------------------------------
module tb_div_n;

    logic        clk;
    logic        rst;
    logic        init_u, init_s, init_w;
    logic [15:0] a16, b16;
    logic [31:0] a32, b32;

    logic [15:0] q_u, r_u, q_s, r_s;
    logic [31:0] q_w, r_w;
    logic        busy_u, done_u, dv0_u;
    logic        busy_s, done_s, dv0_s;
    logic        busy_w, done_w, dv0_w;

    int n_checks;
    int n_fail;

    int          sel;
    logic [31:0] obs_q, obs_r;
    logic        obs_busy, obs_done, obs_dv0;

    div_n #(.WIDTH(16), .SIGNED(0)) u_div_u16 (
        .clk(clk), .rst(rst), .init_in(init_u), .A(a16), .B(b16),
        .quotient(q_u), .remainder(r_u), .busy(busy_u), .done(done_u), .dv0(dv0_u)
    );

    div_n #(.WIDTH(16), .SIGNED(1)) u_div_s16 (
        .clk(clk), .rst(rst), .init_in(init_s), .A(a16), .B(b16),
        .quotient(q_s), .remainder(r_s), .busy(busy_s), .done(done_s), .dv0(dv0_s)
    );

    div_n #(.WIDTH(32), .SIGNED(0)) u_div_u32 (
        .clk(clk), .rst(rst), .init_in(init_w), .A(a32), .B(b32),
        .quotient(q_w), .remainder(r_w), .busy(busy_w), .done(done_w), .dv0(dv0_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obs_q    = {16'h0, q_u};
        obs_r    = {16'h0, r_u};
        obs_busy = busy_u;
        obs_done = done_u;
        obs_dv0  = dv0_u;
        if (sel == 1) begin
            obs_q    = {16'h0, q_s};
            obs_r    = {16'h0, r_s};
            obs_busy = busy_s;
            obs_done = done_s;
            obs_dv0  = dv0_s;
        end else if (sel == 2) begin
            obs_q    = q_w;
            obs_r    = r_w;
            obs_busy = busy_w;
            obs_done = done_w;
            obs_dv0  = dv0_w;
        end
    end

    // Reference: plain integer division on the operand width.
    function automatic void model(input int dut, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic d0, output int lat, output int bcnt);
        longint sa, sb, qq, rr;
        int w;
        w = (dut == 2) ? 32 : 16;
        if (w == 16) begin
            a = {16'h0, a[15:0]};
            b = {16'h0, b[15:0]};
        end
        if (b == 32'h0) begin
            q    = (w == 16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            r    = a;
            d0   = 1'b1;
            lat  = 1;
            bcnt = 0;
        end else begin
            d0   = 1'b0;
            lat  = w + 1;
            bcnt = w;
            if (dut == 1) begin
                sa = longint'($signed(a[15:0]));
                sb = longint'($signed(b[15:0]));
                qq = sa / sb;
                rr = sa % sb;
                q  = {16'h0, 16'(qq)};
                r  = {16'h0, 16'(rr)};
            end else begin
                q = a / b;
                r = a % b;
            end
        end
    endfunction

    // Issue a one-cycle start on the selected instance; returns at the first
    // sample point after the accepting edge. Operands are scrambled afterwards.
    task automatic start_div(input int dut, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        sel = dut;
        a16 = a[15:0];
        b16 = b[15:0];
        a32 = a;
        b32 = b;
        if (dut == 0) init_u = 1'b1;
        else if (dut == 1) init_s = 1'b1;
        else init_w = 1'b1;
        @(negedge clk);
        init_u = 1'b0;
        init_s = 1'b0;
        init_w = 1'b0;
        a16 = 16'($urandom);
        b16 = 16'($urandom);
        a32 = $urandom;
        b32 = $urandom;
        #1;
    endtask

    // Count sample points (1 = first after the accepting edge) until done.
    task automatic wait_done(input int first, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int i = first; i < first + 200; i++) begin
            if (obs_busy) bcnt++;
            if (obs_done) begin
                lat = i;
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            n_checks++;
            if ({obs_q, obs_r, obs_busy, obs_done, obs_dv0} !== 67'h0) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: got q=%h r=%h busy=%b done=%b dv0=%b, want all 0",
                         d, obs_q, obs_r, obs_busy, obs_done, obs_dv0);
            end
        end
    endtask

    task automatic test_basic();
        int lat, bcnt;
        start_div(0, 32'd100, 32'd7);
        wait_done(1, lat, bcnt);
        n_checks++; if (obs_q !== 32'd14) begin n_fail++; $display("FAIL basic_q: got %0d want 14", obs_q); end
        n_checks++; if (obs_r !== 32'd2) begin n_fail++; $display("FAIL basic_r: got %0d want 2", obs_r); end
        n_checks++; if (obs_dv0 !== 1'b0) begin n_fail++; $display("FAIL basic_dv0: got %b want 0", obs_dv0); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL basic_latency: got %0d want 17", lat); end
        n_checks++; if (bcnt !== 16) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 16", bcnt); end
    endtask

    task automatic test_div_zero();
        int lat, bcnt;
        start_div(0, 32'd1234, 32'd0);
        wait_done(1, lat, bcnt);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_checks++; if (obs_dv0 !== 1'b1) begin n_fail++; $display("FAIL dz_dv0: got %b want 1", obs_dv0); end
        n_checks++; if (obs_q !== 32'h0000_FFFF) begin n_fail++; $display("FAIL dz_q: got %h want ffff", obs_q); end
        n_checks++; if (obs_r !== 32'd1234) begin n_fail++; $display("FAIL dz_r: got %0d want 1234", obs_r); end
        n_checks++; if (bcnt !== 0) begin n_fail++; $display("FAIL dz_busy: got %0d want 0", bcnt); end
    endtask

    task automatic test_signed();
        int lat, bcnt;
        start_div(1, 32'h0000_FFF9, 32'd2);
        wait_done(1, lat, bcnt);
        n_checks++; if (obs_q !== 32'h0000_FFFD) begin n_fail++; $display("FAIL sgn_q: got %h want fffd", obs_q); end
        n_checks++; if (obs_r !== 32'h0000_FFFF) begin n_fail++; $display("FAIL sgn_r: got %h want ffff", obs_r); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL sgn_latency: got %0d want 17", lat); end
        start_div(1, 32'h0000_8000, 32'h0000_FFFF);
        wait_done(1, lat, bcnt);
        n_checks++; if (obs_q !== 32'h0000_8000) begin n_fail++; $display("FAIL sgn_min_q: got %h want 8000", obs_q); end
        n_checks++; if (obs_r !== 32'h0) begin n_fail++; $display("FAIL sgn_min_r: got %h want 0", obs_r); end
        n_checks++; if (obs_dv0 !== 1'b0) begin n_fail++; $display("FAIL sgn_min_dv0: got %b want 0", obs_dv0); end
    endtask

    task automatic test_ignore_and_back_to_back();
        int lat, bcnt;
        start_div(0, 32'd500, 32'd3);
        repeat (4) begin @(negedge clk); #1; end
        // Now in the 5th CALC cycle: a start request here must be ignored.
        a16 = 16'd9;
        b16 = 16'd9;
        init_u = 1'b1;
        @(negedge clk);
        init_u = 1'b0;
        #1;
        wait_done(6, lat, bcnt);
        n_checks++; if (obs_q !== 32'd166) begin n_fail++; $display("FAIL ignore_q: got %0d want 166", obs_q); end
        n_checks++; if (obs_r !== 32'd2) begin n_fail++; $display("FAIL ignore_r: got %0d want 2", obs_r); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL ignore_latency: got %0d want 17", lat); end
        repeat (3) begin @(negedge clk); #1; end
        n_checks++; if (obs_done !== 1'b1) begin n_fail++; $display("FAIL done_hold: got %b want 1", obs_done); end
        start_div(0, 32'd9, 32'd9);
        n_checks++; if (obs_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_drop: got %b want 0", obs_done); end
        n_checks++; if (obs_q !== 32'd166) begin n_fail++; $display("FAIL b2b_q_hold: got %0d want 166", obs_q); end
        wait_done(1, lat, bcnt);
        n_checks++; if (obs_q !== 32'd1) begin n_fail++; $display("FAIL b2b_q: got %0d want 1", obs_q); end
        n_checks++; if (obs_r !== 32'd0) begin n_fail++; $display("FAIL b2b_r: got %0d want 0", obs_r); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL b2b_latency: got %0d want 17", lat); end
    endtask

    task automatic test_reset_mid_calc();
        int lat, bcnt;
        start_div(0, 32'd60000, 32'd7);
        repeat (7) begin @(negedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({obs_q, obs_r, obs_busy, obs_done, obs_dv0} !== 67'h0) begin
            n_fail++;
            $display("FAIL midcalc_reset: got q=%h r=%h busy=%b done=%b dv0=%b, want all 0",
                     obs_q, obs_r, obs_busy, obs_done, obs_dv0);
        end
        repeat (3) begin @(negedge clk); #1; end
        n_checks++; if (obs_busy !== 1'b0) begin n_fail++; $display("FAIL midcalc_idle_busy: got %b want 0", obs_busy); end
        start_div(0, 32'd60000, 32'd7);
        wait_done(1, lat, bcnt);
        n_checks++; if (obs_q !== 32'd8571) begin n_fail++; $display("FAIL after_rst_q: got %0d want 8571", obs_q); end
        n_checks++; if (obs_r !== 32'd3) begin n_fail++; $display("FAIL after_rst_r: got %0d want 3", obs_r); end
        n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL after_rst_latency: got %0d want 17", lat); end
    endtask

    task automatic test_wide32();
        int lat, bcnt;
        start_div(2, 32'hFFFF_FFFF, 32'd1);
        wait_done(1, lat, bcnt);
        n_checks++; if (obs_q !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL w32_q: got %h want ffffffff", obs_q); end
        n_checks++; if (obs_r !== 32'h0) begin n_fail++; $display("FAIL w32_r: got %h want 0", obs_r); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL w32_latency: got %0d want 33", lat); end
        n_checks++; if (bcnt !== 32) begin n_fail++; $display("FAIL w32_busy_cycles: got %0d want 32", bcnt); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, eq, er;
        logic        ed0;
        int          elat, ebcnt, lat, bcnt, dut;
        for (int n = 0; n < 90; n++) begin
            dut = (n < 35) ? 0 : ((n < 70) ? 1 : 2);
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'h1;
                2: b = 32'($urandom_range(2, 15));
                3: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h0000_8000;
            model(dut, a, b, eq, er, ed0, elat, ebcnt);
            start_div(dut, a, b);
            wait_done(1, lat, bcnt);
            n_checks++;
            if ({obs_q, obs_r, obs_dv0} !== {eq, er, ed0} || lat !== elat || bcnt !== ebcnt) begin
                n_fail++;
                $display("FAIL random dut%0d a=%h b=%h: got q=%h r=%h dv0=%b lat=%0d busy=%0d want q=%h r=%h dv0=%b lat=%0d busy=%0d",
                         dut, a, b, obs_q, obs_r, obs_dv0, lat, bcnt, eq, er, ed0, elat, ebcnt);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sel      = 0;
        rst      = 1'b1;
        init_u   = 1'b0;
        init_s   = 1'b0;
        init_w   = 1'b0;
        a16      = '0;
        b16      = '0;
        a32      = '0;
        b32      = '0;
        test_reset();
        test_basic();
        test_div_zero();
        test_signed();
        test_ignore_and_back_to_back();
        test_reset_mid_calc();
        test_wide32();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
